// File: rtl/bg_mapper_pkg.sv
// Shared types and width helpers for the scaled background mapper.
// Widths are derived from the scaling ratios so the datapath sizes itself per level.
package bg_mapper_pkg;

  typedef enum logic [1:0] {
    SHOWN,
    FADE_OUT,
    DARK,
    FADE_IN
  } fade_state_t;

  // The accumulator holds acc+SRC with acc < DST and SRC <= DST, so it never reaches 2*DST.
  function automatic int dda_acc_width(input int dst);
    return (dst < 1) ? 1 : $clog2(2 * dst);
  endfunction

  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_level(input int colorW);
    return (1 << colorW) - 1;
  endfunction

endpackage

// File: rtl/bg_axis_dda.sv
// One-axis DDA: maps a destination coordinate stream onto source texel indices.
// o_idx reflects this cycle's clear/step so the caller can register the address directly.
module bg_axis_dda
  import bg_mapper_pkg::*;
#(
  parameter int SRC   = 105,
  parameter int DST   = 640,
  parameter int OUT_W = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [OUT_W-1:0] o_idx,
  output logic             o_inc
);

  localparam int ACC_W = dda_acc_width(DST);
  localparam logic [ACC_W-1:0] SRC_L = ACC_W'(SRC);
  localparam logic [ACC_W-1:0] DST_L = ACC_W'(DST);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_accNext;
  logic [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0] r_idx;
  logic [OUT_W-1:0] w_idxNext;

  always_comb begin
    w_sum     = r_acc + SRC_L;
    w_accNext = r_acc;
    w_idxNext = r_idx;
    o_inc     = 1'b0;
    if (i_clear) begin
      w_accNext = '0;
      w_idxNext = '0;
    end else if (i_step) begin
      if (w_sum >= DST_L) begin
        w_accNext = w_sum - DST_L;
        w_idxNext = r_idx + OUT_W'(1);
        o_inc     = 1'b1;
      end else begin
        w_accNext = w_sum;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      r_acc <= w_accNext;
      r_idx <= w_idxNext;
    end
  end

  assign o_idx = w_idxNext;

endmodule

// File: rtl/bg_scaled_mapper.sv
// Scales an indexed ROM image onto the raster with per-axis DDAs, aligns blank to ROM latency,
// and applies a frame-stepped fade between full brightness and black.
module bg_scaled_mapper
  import bg_mapper_pkg::*;
#(
  parameter int IMG_W       = 105,
  parameter int IMG_H       = 117,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int ADDR_W      = 15,
  parameter int IDX_W       = 4,
  parameter int COLOR_W     = 4,
  parameter int ROM_LAT     = 1,
  parameter int FADE_FRAMES = 2
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [COLOR_W-1:0] pal_red,
  input  logic [COLOR_W-1:0] pal_green,
  input  logic [COLOR_W-1:0] pal_blue,
  input  logic               fade_start,
  input  logic               fade_dir,
  output logic               fade_busy,
  output logic               fade_done,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int PIPE_LAT = ROM_LAT + 2;
  localparam int DLY      = PIPE_LAT - 1;
  localparam int CNT_W    = count_width(FADE_FRAMES);
  localparam logic [10:0]        SW_L     = 11'(SCREEN_W);
  localparam logic [10:0]        SH_L     = 11'(SCREEN_H);
  localparam logic [ADDR_W-1:0]  IMG_W_L  = ADDR_W'(IMG_W);
  localparam logic [COLOR_W-1:0] MAX_L    = COLOR_W'(max_level(COLOR_W));
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  logic w_xOn, w_yOn, w_onScreen, w_lineStart, w_frameTick;
  logic w_rowClear, w_rowStep, w_colInc, w_rowInc;
  logic [ADDR_W-1:0] w_colIdx, w_rowIdx, w_rowBaseNext, r_rowBase;
  logic [9:0] r_prevY;
  logic [DLY-1:0] r_visPipe;
  fade_state_t r_state, w_stateNext;
  logic [COLOR_W-1:0] r_level, w_levelNext;
  logic [CNT_W-1:0] r_frameCnt, w_frameCntNext;
  logic r_fadeDone, w_doneNext;
  logic w_unused;

  assign w_xOn       = {1'b0, DrawX} < SW_L;
  assign w_yOn       = {1'b0, DrawY} < SH_L;
  assign w_onScreen  = w_xOn && w_yOn;
  assign w_lineStart = (DrawX == 10'd0);
  assign w_frameTick = w_lineStart && (DrawY == 10'd0);
  assign w_rowClear  = (DrawY == 10'd0);
  assign w_rowStep   = w_lineStart && w_yOn && (DrawY != r_prevY);

  bg_axis_dda #(.SRC(IMG_W), .DST(SCREEN_W), .OUT_W(ADDR_W)) u_colDda (
    .i_clk  (vga_clk),
    .i_rst_n(reset_n),
    .i_clear(w_lineStart),
    .i_step (w_onScreen && !w_lineStart),
    .o_idx  (w_colIdx),
    .o_inc  (w_colInc)
  );

  bg_axis_dda #(.SRC(IMG_H), .DST(SCREEN_H), .OUT_W(ADDR_W)) u_rowDda (
    .i_clk  (vga_clk),
    .i_rst_n(reset_n),
    .i_clear(w_rowClear),
    .i_step (w_rowStep),
    .o_idx  (w_rowIdx),
    .o_inc  (w_rowInc)
  );

  assign w_unused  = &{1'b0, w_colInc, w_rowIdx};
  assign pal_index = rom_q;

  // Row base tracks row*IMG_W by accumulation, in step with the row DDA.
  always_comb begin
    w_rowBaseNext = r_rowBase;
    if (w_rowClear) begin
      w_rowBaseNext = '0;
    end else if (w_rowInc) begin
      w_rowBaseNext = r_rowBase + IMG_W_L;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_address <= '0;
      r_rowBase   <= '0;
      r_prevY     <= '0;
      r_visPipe   <= '0;
    end else begin
      r_rowBase   <= w_rowBaseNext;
      rom_address <= w_onScreen ? (w_colIdx + w_rowBaseNext) : '0;
      r_visPipe   <= {r_visPipe[DLY-2:0], blank && w_onScreen};
      if (w_lineStart) r_prevY <= DrawY;
    end
  end

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] ch,
                                               input logic [COLOR_W-1:0] lvl);
    logic [2*COLOR_W-1:0] prod;
    prod = {{COLOR_W{1'b0}}, ch} * {{COLOR_W{1'b0}}, lvl};
    return (lvl == MAX_L) ? ch : prod[2*COLOR_W-1:COLOR_W];
  endfunction

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (r_visPipe[DLY-1]) begin
      red   <= scale(pal_red, r_level);
      green <= scale(pal_green, r_level);
      blue  <= scale(pal_blue, r_level);
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state    <= SHOWN;
      r_level    <= MAX_L;
      r_frameCnt <= '0;
      r_fadeDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_level    <= w_levelNext;
      r_frameCnt <= w_frameCntNext;
      r_fadeDone <= w_doneNext;
    end
  end

  // Requests are only honoured from the opposite resting state; fades step on frame ticks.
  always_comb begin
    w_stateNext    = r_state;
    w_levelNext    = r_level;
    w_frameCntNext = r_frameCnt;
    w_doneNext     = 1'b0;
    case (r_state)
      SHOWN: if (fade_start && !fade_dir) begin
        w_stateNext    = FADE_OUT;
        w_frameCntNext = '0;
      end
      DARK: if (fade_start && fade_dir) begin
        w_stateNext    = FADE_IN;
        w_frameCntNext = '0;
      end
      FADE_OUT: if (w_frameTick) begin
        if (r_frameCnt == CNT_LAST) begin
          w_frameCntNext = '0;
          w_levelNext    = r_level - COLOR_W'(1);
          if (r_level == COLOR_W'(1)) begin
            w_stateNext = DARK;
            w_doneNext  = 1'b1;
          end
        end else begin
          w_frameCntNext = r_frameCnt + CNT_W'(1);
        end
      end
      FADE_IN: if (w_frameTick) begin
        if (r_frameCnt == CNT_LAST) begin
          w_frameCntNext = '0;
          w_levelNext    = r_level + COLOR_W'(1);
          if (r_level == MAX_L - COLOR_W'(1)) begin
            w_stateNext = SHOWN;
            w_doneNext  = 1'b1;
          end
        end else begin
          w_frameCntNext = r_frameCnt + CNT_W'(1);
        end
      end
      default: w_stateNext = SHOWN;
    endcase
  end

  assign fade_busy = (r_state == FADE_OUT) || (r_state == FADE_IN);
  assign fade_done = r_fadeDone;

endmodule
